bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It converts a WIDTH-bit binary operand into DIGITS packed BCD digits over WIDTH clock cycles, using a start/busy/done handshake. It extends the existing combinational 8-bit hundreds/tens/units decoder with arbitrary width, a configurable digit count, overflow detection and optional signed input. It sits between datapath counters and display/UART formatting logic.

## Interface
- WIDTH, 8: binary operand width; WIDTH ≥ 2.
- DIGITS, 3: number of BCD output digits; must be ≥ 1.
- clk  in  1: clock; all state changes on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request a conversion; sampled only in IDLE.
- bin  in  WIDTH: operand; sampled on the edge that accepts start.
- busy  out  1: high while a conversion is in progress.
- done  out  1: one-cycle pulse when a result is written.
- bcd  out  4*DIGITS: packed result; digit 0 (units) is in [3:0].
- ovf  out  1: result did not fit in DIGITS digits; valid with done.
- neg  out  1: sign of the result; present only when BIN2BCD_SIGNED_EN is defined.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE with start=1:
  - latch the operand into a shift register;
  - clear the BCD scratch register and the sticky overflow;
  - load the bit counter with WIDTH;
  - go to SHIFT.
- SHIFT, each cycle:
  - every scratch digit ≥ 5 gets +3 (4-bit, no carry between digits);
  - then {scratch, operand} shifts left by 1;
  - the bit shifted out of the top scratch digit ORs into the sticky overflow;
  - the counter decrements.
- Final SHIFT cycle (counter = 1):
  - write the shifted scratch to bcd;
  - write the sticky overflow, including this cycle's shift-out, to ovf;
  - pulse done; return to IDLE.
- When the result overflows, bcd holds value mod 10^DIGITS, because the lower digits are unaffected by truncation.
- start while busy is ignored; bin changes while busy have no effect.
- bcd, ovf and neg hold their value until the next completion.
- Reset mid-conversion aborts: state IDLE, all outputs 0, no done pulse.

## Timing
- Reset values: busy=0, done=0, bcd=0, ovf=0, neg=0; state IDLE.
- start accepted on edge E0: busy=1 from E0.
- Shifts occur on edges E1..E_WIDTH.
- Edge E_WIDTH: bcd/ovf/neg updated, done=1, busy=0.
- Edge E_WIDTH+1: done=0.
- Latency is exactly WIDTH cycles from accept to done, independent of the operand value.
- start high in the done cycle (state IDLE) is accepted, giving back-to-back throughput of one result per WIDTH+1 cycles.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - bin is two's complement;
  - at accept, the magnitude (−bin if the MSB is set) is loaded and neg latches the MSB;
  - −2^(WIDTH−1) converts correctly as an unsigned magnitude;
  - neg is updated together with bcd.
- Not defined: bin is unsigned, the neg port and its logic are absent, and the behaviour is otherwise identical.

## Structure
- Package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT);
  - constants DIGIT_W=4, ADJ_THRESH=5, ADJ_ADD=3;
  - a function min_digits(width) that the bench uses to choose non-overflowing DIGITS.
- Sub-module bcd_digit_adj: a combinational 4-bit "≥5 then +3" cell, instantiated DIGITS times by a generate loop.
- The counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=8, DIGITS=3, bin=0, start pulse → done exactly 8 cycles after accept, bcd=12'h000, ovf=0.
- bin=234 then bin=255, back-to-back (start held through the done cycle) → bcd=12'h234, then bcd=12'h255; two done pulses 9 cycles apart.
- bin=4, then start re-asserted twice while busy with bin=99 → single done, bcd=12'h004; the busy-time starts are ignored.
- Reset asserted 3 cycles into converting bin=22 → outputs immediately 0 and no done; a fresh start converts bin=22 → 12'h022.
- DIGITS=2, bin=234 → ovf=1, bcd=8'h34; then bin=99 → ovf=0, bcd=8'h99.
- BIN2BCD_SIGNED_EN: bin=8'hEA (−22) → neg=1, bcd=12'h022; bin=8'h80 → neg=1, bcd=12'h128; bin=8'h7F → neg=0, bcd=12'h127.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the sequential double-dabble converter.
//   state_e      : converter FSM states (IDLE, SHIFT)
//   DIGIT_W      : bits per BCD digit
//   ADJ_THRESH   : digit value at which the +3 pre-shift correction applies
//   ADJ_ADD      : correction amount
//   min_digits() : decimal digits needed to hold any unsigned width-bit value
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Digits of (2^width - 1) = floor(width * log10(2)) + 1; 2^width is never
  // a power of ten, so the floor form is exact for any practical width.
  function automatic int min_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell for one BCD digit: a digit of
// 5 or more gets +3 so that the following left shift carries correctly into
// the next decimal digit. 4-bit result, no carry out.
//   digit_i : scratch digit before correction
//   digit_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= DIGIT_W'(ADJ_THRESH)) ? (digit_i + DIGIT_W'(ADJ_ADD))
                                                     : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). One operand bit is
// consumed per cycle, so a conversion takes exactly WIDTH cycles.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input, adds neg).
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : conversion request, sampled only in IDLE
//   bin    : operand, sampled on the accepting edge
//   busy   : conversion in progress
//   done   : one-cycle pulse when bcd/ovf(/neg) are written
//   bcd    : packed BCD result, units digit in [3:0]
//   ovf    : result exceeded DIGITS digits (bcd then holds value mod 10^DIGITS)
//   neg    : sign of the result (BIN2BCD_SIGNED_EN only)
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    ovf
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                    neg
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sr_q,     sr_d;
  logic [BCD_W-1:0]   scr_q,    scr_d;
  logic               sticky_q, sticky_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic               ovf_q,    ovf_d;
`ifdef BIN2BCD_SIGNED_EN
  logic               sign_q,   sign_d;
  logic               neg_q,    neg_d;
`endif

  logic [BCD_W-1:0]   scr_adj;
  logic [BCD_W-1:0]   scr_shift;
  logic [WIDTH-1:0]   sr_shift;
  logic               shift_out;
  logic [WIDTH-1:0]   load_val;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (scr_q[gi*DIGIT_W +: DIGIT_W]),
        .digit_o (scr_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // {scratch, operand} shifted left by one after correction; the top scratch
  // bit falls off and feeds the sticky overflow.
  assign shift_out = scr_adj[BCD_W-1];
  assign scr_shift = {scr_adj[BCD_W-2:0], sr_q[WIDTH-1]};
  assign sr_shift  = {sr_q[WIDTH-2:0], 1'b0};

`ifdef BIN2BCD_SIGNED_EN
  // Negating -2^(WIDTH-1) wraps to the same bit pattern, which read as
  // unsigned is exactly the wanted magnitude.
  assign load_val = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
`else
  assign load_val = bin;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    scr_d    = scr_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d   = sign_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d     = load_val;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(WIDTH);
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
          sign_d   = bin[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sr_d     = sr_shift;
        scr_d    = scr_shift;
        sticky_d = sticky_q | shift_out;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scr_shift;
          ovf_d   = sticky_q | shift_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = sign_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      scr_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q   <= sign_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
  assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Two converters share start/bin: dut_a (WIDTH=8, DIGITS=3) and dut_b
// (WIDTH=8, DIGITS=2, so large operands overflow). Results are compared with
// a decimal model built from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic        neg_a, neg_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg_a)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
`ifdef BIN2BCD_SIGNED_EN
    , .neg(neg_b)
`endif
  );

`ifndef BIN2BCD_SIGNED_EN
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic        neg;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
      $display("ok   %-12s act=%0h exp=%0h", nm, act, exp);
    end else begin
      $display("FAIL %-12s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Magnitude of the operand as the converter should interpret it.
  function automatic int mag(input logic [7:0] b);
`ifdef BIN2BCD_SIGNED_EN
    return b[7] ? (256 - int'(b)) : int'(b);
`else
    return int'(b);
`endif
  endfunction

  function automatic logic is_neg(input logic [7:0] b);
`ifdef BIN2BCD_SIGNED_EN
    return b[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] dec(input int v, input int d);
    logic [11:0] r;
    int lim;
    r = '0;
    lim = 10 ** d;
    v = v % lim;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Wait (bounded) for done on dut_a; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_a && n < 20);
    if (!done_a) $display("FAIL timeout     no done within %0d cycles", n);
  endtask

  task automatic model_chk(input logic [7:0] b);
    int v;
    v = mag(b);
    chk("bcd_a", bcd_a, dec(v, 3));
    chk("ovf_a", ovf_a, v >= 1000);
    chk("bcd_b", bcd_b, dec(v, 2));
    chk("ovf_b", ovf_b, v >= 100);
    chk("neg_a", neg_a, is_neg(b));
    chk("neg_b", neg_b, is_neg(b));
  endtask

  // One full handshake: accept, latency, done pulse; results left on outputs
  // while done is high. Caller checks results, then calls after_done.
  task automatic run(input logic [7:0] b);
    int n;
    start = 1'b1;
    bin   = b;
    tick();
    chk("busy_acc", busy_a, 1'b1);
    chk("done_acc", done_a, 1'b0);
    start = 1'b0;
    bin   = ~b;
    wait_done(n);
    chk("latency", n, 8);
    chk("busy_end", busy_a, 1'b0);
    chk("done_b", done_b, 1'b1);
  endtask

  task automatic after_done();
    logic [11:0] held;
    held = bcd_a;
    tick();
    chk("done_fall", done_a, 1'b0);
    chk("bcd_hold", bcd_a, held);
  endtask

  initial begin
    int n, m, pulses;
`ifdef BIN2BCD_SIGNED_EN
    tbl[0] = '{8'hEA, 12'h022, 1'b0, 1'b1};
    tbl[1] = '{8'h80, 12'h128, 1'b0, 1'b1};
    tbl[2] = '{8'h7F, 12'h127, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 12'h000, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 12'h001, 1'b0, 1'b1};
    tbl[5] = '{8'h9C, 12'h100, 1'b0, 1'b1};
    tbl[6] = '{8'h63, 12'h099, 1'b0, 1'b0};
    tbl[7] = '{8'h16, 12'h022, 1'b0, 1'b0};
`else
    tbl[0] = '{8'd0,   12'h000, 1'b0, 1'b0};
    tbl[1] = '{8'd234, 12'h234, 1'b0, 1'b0};
    tbl[2] = '{8'd255, 12'h255, 1'b0, 1'b0};
    tbl[3] = '{8'd4,   12'h004, 1'b0, 1'b0};
    tbl[4] = '{8'd99,  12'h099, 1'b0, 1'b0};
    tbl[5] = '{8'd22,  12'h022, 1'b0, 1'b0};
    tbl[6] = '{8'd100, 12'h100, 1'b0, 1'b0};
    tbl[7] = '{8'd9,   12'h009, 1'b0, 1'b0};
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_bcd", bcd_a, 12'h000);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_neg", neg_a, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].bin);
      chk("tbl_bcd", bcd_a, tbl[i].bcd);
      chk("tbl_ovf", ovf_a, tbl[i].ovf);
      chk("tbl_neg", neg_a, tbl[i].neg);
      model_chk(tbl[i].bin);
      after_done();
    end

    // Overflow on the two-digit instance, then a fitting value
`ifdef BIN2BCD_SIGNED_EN
    run(8'h9C);
    chk("ovf2_bcd", bcd_b, 8'h00);
`else
    run(8'd234);
    chk("ovf2_bcd", bcd_b, 8'h34);
`endif
    chk("ovf2_ovf", ovf_b, 1'b1);
    after_done();
    run(8'd99);
    chk("fit2_bcd", bcd_b, 8'h99);
    chk("fit2_ovf", ovf_b, 1'b0);
    after_done();

    // Back-to-back: start held through the done cycle
    start = 1'b1;
    bin   = 8'd234;
    tick();
    wait_done(n);
    chk("b2b_lat1", n, 8);
    model_chk(8'd234);
    bin = 8'd255;
    tick();
    chk("b2b_done0", done_a, 1'b0);
    chk("b2b_busy", busy_a, 1'b1);
    start = 1'b0;
    wait_done(m);
    chk("b2b_gap", m + 1, 9);
    model_chk(8'd255);
    after_done();

    // Starts while busy are ignored
    start = 1'b1;
    bin   = 8'd4;
    tick();
    start = 1'b0;
    bin   = 8'd99;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ign_lat", n + 4, 8);
    model_chk(8'd4);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_a) pulses++;
    end
    chk("ign_pulses", pulses, 0);
    chk("ign_bcd", bcd_a, dec(mag(8'd4), 3));

    // Reset mid-conversion
    start = 1'b1;
    bin   = 8'd22;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_bcd", bcd_a, 12'h000);
    chk("abort_done", done_a, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    run(8'd22);
    chk("abort_rerun", bcd_a, 12'h022);
    after_done();

    // Randomized operands against the decimal model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      run(r);
      model_chk(r);
      after_done();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
